bft_leaf_port: RTL and testbench
================================

Name: bft_leaf_port

Overview:
- Leaf-side endpoint of the BFT deflection network: the far end of the switch up-links whose turnback/deflection decisions the t/pi arbiters make.
- Injects user packets upward into the tree.
- Accepts packets delivered down from the tree.
- Re-injects any packet it cannot or must not consume, because the network is bufferless: every valid packet arriving at a leaf must leave it on the next slot.
- One instance per processing element, between the user logic and the level-0 switch port.

Parameters:
- ADDR_BITS, 5, destination leaf address width.
- PAYLOAD_BITS, 32, user payload width.
- POSITION, 0, this leaf's address; packets with addr==POSITION are local.
- TX_DEPTH, 4, tx FIFO entries (power of two, >=2).
- RX_DEPTH, 4, rx FIFO entries (power of two, >=2).

Ports:
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- din_addr, in, ADDR_BITS, tx destination.
- din_payload, in, PAYLOAD_BITS, tx payload.
- din_valid, in, 1, tx request.
- din_ready, out, 1, tx FIFO not full.
- pe_out, out, PACKET_BITS, packet to tree up-link; MSB = valid.
- pe_in, in, PACKET_BITS, packet from tree down-link; MSB = valid.
- dout_addr, out, ADDR_BITS, source-agnostic address field of the delivered packet.
- dout_payload, out, PAYLOAD_BITS, delivered payload.
- dout_valid, out, 1, rx FIFO not empty.
- dout_ready, in, 1, user accepts dout.

Behaviour:
- Packet format: PACKET_BITS = 1+ADDR_BITS+PAYLOAD_BITS, laid out as {valid, addr, payload}. A packet with MSB=0 is VOID; its other bits are don't-care, driven 0.
- Reset (synchronous; takes effect mid-transfer too):
  - both FIFOs are emptied and pe_out=0.
  - din_ready=0 during the reset cycle, then 1.
  - dout_valid=0.
  - An in-flight pe_in packet in the reset cycle is dropped.
- Input classification, one slot per cycle on pe_in:
  - DELIVER: valid, addr==POSITION, rx FIFO not full. Pushed to rx.
  - BOUNCE: valid, addr==POSITION, rx FIFO full at the start of the cycle (a same-cycle pop does not free space). Re-injected unchanged.
  - MISROUTE: valid, addr!=POSITION. Re-injected unchanged.
  - IDLE: invalid.
- pe_out is registered (1-cycle latency). Priority: BOUNCE/MISROUTE packet > tx FIFO head > VOID. The tx head is popped only when it wins the slot. An inbound re-injection therefore stalls local injection for exactly that cycle, so no packet is ever dropped.
- Local-to-self tx (din_addr==POSITION) is injected to the tree like any other packet, not looped back internally.
- tx FIFO:
  - din accepted when din_valid & din_ready.
  - A simultaneous push and pop when full is not allowed (din_ready is computed from the registered count, not bypassed).
- rx FIFO:
  - dout presents the head.
  - Pops on dout_valid & dout_ready.
  - Push and pop in the same cycle are legal at any occupancy except push-when-full.
  - Zero fall-through: a packet appears on dout the cycle after pe_in.
- Pointers wrap modulo depth. Count width is clog2(depth)+1, so full (count==DEPTH) and empty (count==0) are unambiguous.
- The output selection is a 3-state per-cycle choice: SEL_VOID, SEL_REINJECT, SEL_TX. It is encoded in a 2-bit mux select using the shared direction encoding (VOID=00, UP=11 for re-inject, LEFT=01 for local tx).

Optional Feature:
- Macro: BFT_LEAF_STATS_EN.
- When defined, adds three outputs: stat_injected, stat_delivered, stat_reinjected, each 32 bits.
  - Counters increment on tx pop, rx push, and BOUNCE/MISROUTE respectively.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, the ports and counter logic are absent, with no other behavioural change.

Decomposition:
- Shared package/include:
  - the VOID/LEFT/RIGHT/UP direction constants, reusing the existing direction parameter header;
  - packet field offset macros: valid bit, addr MSB/LSB, payload LSB.
- One natural sub-module, bft_sync_fifo: parameterised WIDTH/DEPTH, sync reset, full/empty/count. Instantiated twice (tx width ADDR_BITS+PAYLOAD_BITS; rx same).

Test Plan:
- Reset, then din {addr=3, payload=32'hA5A5_0001} with POSITION=0 and pe_in VOID → pe_out = {1, 5'd3, 32'hA5A5_0001} exactly 2 cycles after acceptance (1 cycle for the FIFO, 1 for the registered output).
- pe_in = {1, 5'd0, 32'hDEAD_BEEF} with dout_ready=1 → dout_valid=1 and dout_payload=32'hDEAD_BEEF next cycle; pe_out stays VOID.
- Hold dout_ready=0 and send 5 local packets (RX_DEPTH=4) → first 4 are buffered; the 5th appears unchanged on pe_out next cycle; stat_reinjected=1.
- tx FIFO holds 2 packets and pe_in carries misrouted {1, 5'd7, X} → pe_out carries the addr-7 packet; the tx head is delayed exactly 1 cycle; no loss. Injected and re-injected packet order matches the expected sequence.
- Fill tx with 4 packets while pe_in is continuously misrouted → din_ready=0; no tx pop; the FIFO count holds at 4. When pe_in goes VOID, the 4 packets drain on consecutive cycles.
- Assert reset with 3 tx and 2 rx entries pending → next cycle: dout_valid=0, pe_out=0, din_ready=1 one cycle after reset deasserts, and stats=0.

Source files
------------

// File: rtl/bft_leaf_port_pkg.sv
// rtl/bft_leaf_port_pkg.sv - shared direction encoding, output-select type and packet field offsets
package bft_leaf_port_pkg;

  localparam logic [1:0] DIR_VOID  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  // Leaf up-link select reuses the switch direction codes: local tx rides LEFT, re-inject rides UP
  typedef enum logic [1:0] {
    SEL_VOID     = DIR_VOID,
    SEL_TX       = DIR_LEFT,
    SEL_REINJECT = DIR_UP
  } sel_e;

  localparam int PKT_PAYLOAD_LSB = 0;

  function automatic int pkt_valid_bit(input int addr_bits, input int payload_bits);
    return addr_bits + payload_bits;
  endfunction

  function automatic int pkt_addr_msb(input int addr_bits, input int payload_bits);
    return addr_bits + payload_bits - 1;
  endfunction

  function automatic int pkt_addr_lsb(input int addr_bits, input int payload_bits);
    return payload_bits + 0 * addr_bits;
  endfunction

endpackage

// File: rtl/bft_leaf_port_sync_fifo.sv
// rtl/bft_leaf_port_sync_fifo.sv - bft_sync_fifo: synchronous FIFO, head visible the cycle after push
module bft_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bft_leaf_port.sv
// rtl/bft_leaf_port.sv - BFT leaf endpoint: inject, deliver, re-inject bounced/misrouted packets
// Optional saturating traffic counters under BFT_LEAF_STATS_EN.
module bft_leaf_port
  import bft_leaf_port_pkg::*;
#(
  parameter int ADDR_BITS    = 5,
  parameter int PAYLOAD_BITS = 32,
  parameter int POSITION     = 0,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4,
  localparam int PACKET_BITS = 1 + ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_BITS-1:0]    din_addr,
  input  logic [PAYLOAD_BITS-1:0] din_payload,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [PACKET_BITS-1:0]  pe_out,
  input  logic [PACKET_BITS-1:0]  pe_in,
  output logic [ADDR_BITS-1:0]    dout_addr,
  output logic [PAYLOAD_BITS-1:0] dout_payload,
  output logic                    dout_valid,
  input  logic                    dout_ready
`ifdef BFT_LEAF_STATS_EN
  ,
  output logic [31:0]             stat_injected,
  output logic [31:0]             stat_delivered,
  output logic [31:0]             stat_reinjected
`endif
);

  localparam int ENTRY_BITS = ADDR_BITS + PAYLOAD_BITS;
  localparam int VALID_BIT  = pkt_valid_bit(ADDR_BITS, PAYLOAD_BITS);
  localparam int ADDR_MSB   = pkt_addr_msb(ADDR_BITS, PAYLOAD_BITS);
  localparam int ADDR_LSB   = pkt_addr_lsb(ADDR_BITS, PAYLOAD_BITS);

  logic [ENTRY_BITS-1:0]       tx_head, rx_head;
  logic                        tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0]   tx_count;
  logic [$clog2(RX_DEPTH):0]   rx_count;
  logic                        tx_push, tx_pop, rx_push, rx_pop;
  logic                        in_valid, in_local, reinject;
  sel_e                        sel_d;
  logic [PACKET_BITS-1:0]      pe_out_q, pe_out_d;
  logic                        unused_counts;

  assign unused_counts = ^{tx_count, rx_count};

  assign in_valid = pe_in[VALID_BIT];
  assign in_local = (pe_in[ADDR_MSB:ADDR_LSB] == ADDR_BITS'(POSITION));
  assign rx_push  = in_valid & in_local & ~rx_full;
  assign reinject = in_valid & (~in_local | rx_full);

  assign din_ready = ~tx_full & ~reset;
  assign tx_push   = din_valid & din_ready;

  assign dout_valid   = ~rx_empty;
  assign rx_pop       = dout_valid & dout_ready;
  assign dout_addr    = rx_head[ADDR_MSB:ADDR_LSB];
  assign dout_payload = rx_head[PKT_PAYLOAD_LSB +: PAYLOAD_BITS];

  // The network is bufferless: an inbound packet we cannot keep must take this slot
  always_comb begin
    sel_d = SEL_VOID;
    if (reinject)       sel_d = SEL_REINJECT;
    else if (!tx_empty) sel_d = SEL_TX;
  end

  assign tx_pop = (sel_d == SEL_TX);

  always_comb begin
    pe_out_d = '0;
    case (sel_d)
      SEL_REINJECT: pe_out_d = pe_in;
      SEL_TX:       pe_out_d = {1'b1, tx_head};
      default:      pe_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pe_out_q <= '0;
    else       pe_out_q <= pe_out_d;
  end

  assign pe_out = pe_out_q;

  bft_sync_fifo #(.WIDTH(ENTRY_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tx_push),
    .push_data_i ({din_addr, din_payload}),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  bft_sync_fifo #(.WIDTH(ENTRY_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rx_push),
    .push_data_i (pe_in[ENTRY_BITS-1:0]),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

`ifdef BFT_LEAF_STATS_EN
  logic [31:0] injected_q, delivered_q, reinjected_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      injected_q   <= '0;
      delivered_q  <= '0;
      reinjected_q <= '0;
    end else begin
      if (tx_pop && injected_q != '1)     injected_q   <= injected_q + 32'd1;
      if (rx_push && delivered_q != '1)   delivered_q  <= delivered_q + 32'd1;
      if (reinject && reinjected_q != '1) reinjected_q <= reinjected_q + 32'd1;
    end
  end

  assign stat_injected   = injected_q;
  assign stat_delivered  = delivered_q;
  assign stat_reinjected = reinjected_q;
`endif

endmodule

// File: tb/tb_bft_leaf_port.sv
// tb/tb_bft_leaf_port.sv - directed self-checking bench for bft_leaf_port (POSITION=0, depths 4)
module tb_bft_leaf_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  din_addr;
  logic [31:0] din_payload;
  logic        din_valid;
  logic        din_ready;
  logic [37:0] pe_out;
  logic [37:0] pe_in;
  logic [4:0]  dout_addr;
  logic [31:0] dout_payload;
  logic        dout_valid;
  logic        dout_ready;
`ifdef BFT_LEAF_STATS_EN
  logic [31:0] stat_injected, stat_delivered, stat_reinjected;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bft_leaf_port #(
    .ADDR_BITS(5), .PAYLOAD_BITS(32), .POSITION(0), .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din_addr     (din_addr),
    .din_payload  (din_payload),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .pe_out       (pe_out),
    .pe_in        (pe_in),
    .dout_addr    (dout_addr),
    .dout_payload (dout_payload),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready)
`ifdef BFT_LEAF_STATS_EN
    ,
    .stat_injected   (stat_injected),
    .stat_delivered  (stat_delivered),
    .stat_reinjected (stat_reinjected)
`endif
  );

  typedef struct {
    logic        dv;
    logic [4:0]  a;
    logic [31:0] p;
    logic [37:0] pin;
    logic [37:0] exp_out;
    logic        exp_rdy;
  } step_t;

  step_t tbl [16];

  function automatic logic [37:0] pkt(input logic [4:0] a, input logic [31:0] p);
    return {1'b1, a, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Misrouted traffic blocks a 2-deep tx backlog, then a 4-deep backlog with one refused push
    tbl[0]  = '{1'b1, 5'd1, 32'h201, pkt(5'd7, 32'h701), pkt(5'd7, 32'h701), 1'b1};
    tbl[1]  = '{1'b1, 5'd2, 32'h202, pkt(5'd7, 32'h702), pkt(5'd7, 32'h702), 1'b1};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,   pkt(5'd7, 32'h703), pkt(5'd7, 32'h703), 1'b1};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd1, 32'h201), 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd2, 32'h202), 1'b1};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,   38'h0,              38'h0,              1'b1};
    tbl[6]  = '{1'b1, 5'd4, 32'h301, pkt(5'd9, 32'h901), pkt(5'd9, 32'h901), 1'b1};
    tbl[7]  = '{1'b1, 5'd5, 32'h302, pkt(5'd9, 32'h902), pkt(5'd9, 32'h902), 1'b1};
    tbl[8]  = '{1'b1, 5'd0, 32'h303, pkt(5'd9, 32'h903), pkt(5'd9, 32'h903), 1'b1};
    tbl[9]  = '{1'b1, 5'd7, 32'h304, pkt(5'd9, 32'h904), pkt(5'd9, 32'h904), 1'b1};
    tbl[10] = '{1'b1, 5'd8, 32'h305, pkt(5'd9, 32'h905), pkt(5'd9, 32'h905), 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd4, 32'h301), 1'b0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd5, 32'h302), 1'b1};
    tbl[13] = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd0, 32'h303), 1'b1};
    tbl[14] = '{1'b0, 5'd0, 32'h0,   38'h0,              pkt(5'd7, 32'h304), 1'b1};
    tbl[15] = '{1'b0, 5'd0, 32'h0,   38'h0,              38'h0,              1'b1};

    reset = 1'b1; din_valid = 1'b0; din_addr = '0; din_payload = '0;
    pe_in = '0; dout_ready = 1'b0;
    cyc();
    cyc();
    check("rst_din_ready", 64'(din_ready), 64'd0);
    check("rst_pe_out", 64'(pe_out), 64'd0);
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_din_ready", 64'(din_ready), 64'd1);

    din_addr = 5'd3; din_payload = 32'hA5A5_0001; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    check("tx_lat1_void", 64'(pe_out), 64'd0);
    cyc();
    check("tx_lat2_pkt", 64'(pe_out), 64'(pkt(5'd3, 32'hA5A5_0001)));
    cyc();
    check("tx_after_void", 64'(pe_out), 64'd0);

    pe_in = pkt(5'd0, 32'hDEAD_BEEF); dout_ready = 1'b1;
    cyc();
    pe_in = '0;
    check("rx_valid", 64'(dout_valid), 64'd1);
    check("rx_payload", 64'(dout_payload), 64'hDEAD_BEEF);
    check("rx_addr", 64'(dout_addr), 64'd0);
    check("rx_pe_out_void", 64'(pe_out), 64'd0);
    cyc();
    check("rx_popped", 64'(dout_valid), 64'd0);

    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pe_in = pkt(5'd0, 32'h100 + 32'(i));
      cyc();
      if (i == 3) check("bounce_pre_void", 64'(pe_out), 64'd0);
    end
    pe_in = '0;
    check("bounce_pe_out", 64'(pe_out), 64'(pkt(5'd0, 32'h104)));
`ifdef BFT_LEAF_STATS_EN
    check("stat_reinjected", 64'(stat_reinjected), 64'd1);
    check("stat_delivered", 64'(stat_delivered), 64'd5);
    check("stat_injected", 64'(stat_injected), 64'd1);
`endif
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid%0d", i), 64'(dout_valid), 64'd1);
      check($sformatf("drain_payload%0d", i), 64'(dout_payload), 64'(32'h100 + 32'(i)));
      cyc();
    end
    check("drain_empty", 64'(dout_valid), 64'd0);
    dout_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      din_valid = tbl[i].dv; din_addr = tbl[i].a; din_payload = tbl[i].p; pe_in = tbl[i].pin;
      #1;
      check($sformatf("tbl_rdy%0d", i), 64'(din_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl_out%0d", i), 64'(pe_out), 64'(tbl[i].exp_out));
    end

    pe_in = pkt(5'd0, 32'hA1);
    cyc();
    pe_in = pkt(5'd0, 32'hA2);
    cyc();
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_addr = 5'(i + 1); din_payload = 32'hB0 + 32'(i); pe_in = pkt(5'd7, 32'hC0 + 32'(i));
      cyc();
    end
    din_valid = 1'b0;
    check("pre_rst_rx_valid", 64'(dout_valid), 64'd1);
    check("pre_rst_rx_head", 64'(dout_payload), 64'hA1);
    check("pre_rst_pe_out", 64'(pe_out), 64'(pkt(5'd7, 32'hC2)));
    reset = 1'b1; pe_in = pkt(5'd0, 32'hA3);
    #1;
    check("mid_rst_din_ready", 64'(din_ready), 64'd0);
    cyc();
    reset = 1'b0; pe_in = '0;
    #1;
    check("rst2_dout_valid", 64'(dout_valid), 64'd0);
    check("rst2_pe_out", 64'(pe_out), 64'd0);
    check("rst2_din_ready", 64'(din_ready), 64'd1);
`ifdef BFT_LEAF_STATS_EN
    check("rst2_stats", 64'({stat_injected, stat_delivered} | 64'(stat_reinjected)), 64'd0);
`endif
    cyc();
    check("rst2_tx_flushed", 64'(pe_out), 64'd0);
    check("rst2_inflight_dropped", 64'(dout_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
